// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller beside ID: tracks in-flight destinations through
// EX..WB and produces forward selects, load-use stalls and issue control.
module hazard_scoreboard #(
  parameter int REG_W       = 5,
  parameter int DEPTH       = 3,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG    = 31,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [REG_W-1:0]           id_ra,
  input  logic                       id_ra_used,
  input  logic [REG_W-1:0]           id_rb,
  input  logic                       id_rb_used,
  input  logic [REG_W-1:0]           id_rw,
  input  logic                       id_wr_en,
  input  logic                       id_is_load,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel_a,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel_b,
  output logic                       stall,
  output logic                       issue,
  output logic [DEPTH-1:0]           slot_valid,
  output logic [CNT_W-1:0]           stall_count
);

  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam int unsigned LL = LOAD_LAT;
  localparam int unsigned FS = FLUSH_SLOTS;
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  typedef struct packed {
    logic             v;
    logic             ld;
    logic [REG_W-1:0] rw;
  } entry_t;

  // slot[0] is slot 1 (EX, youngest); slot[DEPTH-1] is WB
  entry_t slot [DEPTH];

  logic             hit_a, hit_b, rdy_a, rdy_b;
  logic [SEL_W-1:0] k_a, k_b;

  // Scan oldest to youngest so the last hit left standing is the youngest producer
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    k_a   = '0;
    k_b   = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (slot[k-1].v && slot[k-1].rw == id_ra && id_ra_used && id_ra != ZR) begin
        hit_a = 1'b1;
        k_a   = SEL_W'(k);
        rdy_a = !slot[k-1].ld || (k > LL);
      end
      if (slot[k-1].v && slot[k-1].rw == id_rb && id_rb_used && id_rb != ZR) begin
        hit_b = 1'b1;
        k_b   = SEL_W'(k);
        rdy_b = !slot[k-1].ld || (k > LL);
      end
    end
  end

  always_comb begin
    stall     = id_valid && !flush && ((hit_a && !rdy_a) || (hit_b && !rdy_b));
    issue     = id_valid && !stall && !flush;
    fwd_sel_a = (id_valid && hit_a && rdy_a) ? k_a : '0;
    fwd_sel_b = (id_valid && hit_b && rdy_b) ? k_b : '0;
  end

  always_comb begin
    slot_valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) slot_valid[k] = slot[k].v;
  end

  // Non-writing instructions enter as bubbles so they can never match a source
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) slot[k] <= '0;
      stall_count <= '0;
    end else begin
      slot[0] <= '{v: issue && id_wr_en, ld: id_is_load, rw: id_rw};
      for (int unsigned k = 1; k < DEPTH; k++) begin
        slot[k] <= slot[k-1];
        if (flush && k <= FS) slot[k].v <= 1'b0;
      end
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default 3-deep instance plus a
// 5-deep, 2-cycle-load, 2-bit-counter instance checked after a shared reset.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_ra;
  logic       id_ra_used;
  logic [4:0] id_rb;
  logic       id_rb_used;
  logic [4:0] id_rw;
  logic       id_wr_en;
  logic       id_is_load;
  logic       flush;

  logic [1:0]  fa_a, fb_a;
  logic        stall_a, issue_a;
  logic [2:0]  sv_a;
  logic [31:0] cnt_a;

  logic [2:0]  fa_b, fb_b;
  logic        stall_b, issue_b;
  logic [4:0]  sv_b;
  logic [1:0]  cnt_b;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_ra(id_ra), .id_ra_used(id_ra_used), .id_rb(id_rb), .id_rb_used(id_rb_used),
    .id_rw(id_rw), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel_a(fa_a), .fwd_sel_b(fb_a), .stall(stall_a), .issue(issue_a),
    .slot_valid(sv_a), .stall_count(cnt_a)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_ra(id_ra), .id_ra_used(id_ra_used), .id_rb(id_rb), .id_rb_used(id_rb_used),
    .id_rw(id_rw), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel_a(fa_b), .fwd_sel_b(fb_b), .stall(stall_b), .issue(issue_b),
    .slot_valid(sv_b), .stall_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] ra, input logic rau,
                        input logic [4:0] rb, input logic rbu, input logic [4:0] rw,
                        input logic wr, input logic ld);
    id_valid   = v;
    id_ra      = ra;
    id_ra_used = rau;
    id_rb      = rb;
    id_rb_used = rbu;
    id_rw      = rw;
    id_wr_en   = wr;
    id_is_load = ld;
    flush      = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    nxt();
    nxt();
    chk("rst_slot_valid", 32'(sv_a), 32'h0);
    chk("rst_stall_count", cnt_a, 32'h0);
    chk("rst_stall", 32'(stall_a), 32'h0);
    chk("rst_issue", 32'(issue_a), 32'h1);
    chk("rst_fwd_a", 32'(fa_a), 32'h0);
    chk("rst_fwd_b", 32'(fb_a), 32'h0);

    // Back-to-back ALU forwarding
    reset = 1'b1;
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);      // ADD X1
    neg();
    chk("alu0_issue", 32'(issue_a), 32'h1);
    chk("alu0_fwd_a", 32'(fa_a), 32'h0);
    nxt();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);      // SUB X3,X1,X2
    neg();
    chk("alu1_fwd_a", 32'(fa_a), 32'h1);
    chk("alu1_fwd_b", 32'(fb_a), 32'h0);
    chk("alu1_stall", 32'(stall_a), 32'h0);
    nxt();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);      // ORR X4,X5,X1
    neg();
    chk("alu2_fwd_a", 32'(fa_a), 32'h0);
    chk("alu2_fwd_b", 32'(fb_a), 32'h2);
    nxt();

    // Load-use with LOAD_LAT=1
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);      // LDUR X5
    neg();
    chk("ld_slot_valid", 32'(sv_a), 32'h7);
    chk("ld_issue", 32'(issue_a), 32'h1);
    nxt();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);      // ADD X6,X5,X5
    neg();
    chk("lu_stall", 32'(stall_a), 32'h1);
    chk("lu_issue", 32'(issue_a), 32'h0);
    nxt();
    neg();
    chk("lu2_stall", 32'(stall_a), 32'h0);
    chk("lu2_issue", 32'(issue_a), 32'h1);
    chk("lu2_fwd_a", 32'(fa_a), 32'h2);
    chk("lu2_fwd_b", 32'(fb_a), 32'h2);
    chk("lu2_count", cnt_a, 32'h1);
    chk("lu2_slot_valid", 32'(sv_a), 32'h6);
    nxt();

    // Youngest producer wins
    set_id(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 1'b0);      // ADD X2
    neg();
    chk("yw0_slot_valid", 32'(sv_a), 32'h5);
    nxt();
    set_id(1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd2, 1'b1, 1'b0);      // SUB X2,X2,X6
    neg();
    chk("yw1_fwd_a", 32'(fa_a), 32'h1);
    chk("yw1_fwd_b", 32'(fb_a), 32'h2);
    nxt();
    set_id(1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0);
    neg();
    chk("yw2_fwd_a", 32'(fa_a), 32'h1);
    chk("yw2_fwd_b", 32'(fb_a), 32'h3);
    nxt();

    // Zero register and unused-source exemptions
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0);
    nxt();
    set_id(1'b1, 5'd31, 1'b1, 5'd10, 1'b0, 5'd11, 1'b1, 1'b0);
    neg();
    chk("xzr_fwd_a", 32'(fa_a), 32'h0);
    chk("unused_fwd_b", 32'(fb_a), 32'h0);
    chk("xzr_stall", 32'(stall_a), 32'h0);
    nxt();
    set_id(1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 1'b0);   // ADD X12,X12,X12
    neg();
    chk("self_fwd_a", 32'(fa_a), 32'h0);
    chk("self_stall", 32'(stall_a), 32'h0);
    nxt();
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 1'b0);    // no write to X13
    neg();
    chk("nowr_fwd_a", 32'(fa_a), 32'h1);
    nxt();
    set_id(1'b1, 5'd13, 1'b1, 5'd12, 1'b1, 5'd14, 1'b1, 1'b0);
    neg();
    chk("nowr_fwd_a2", 32'(fa_a), 32'h0);
    chk("nowr_fwd_b2", 32'(fb_a), 32'h2);
    chk("nowr_slot_valid", 32'(sv_a), 32'h6);
    nxt();

    // Flush over a pending load-use
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);      // LDUR X7
    nxt();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
    flush = 1'b1;
    neg();
    chk("fl_stall", 32'(stall_a), 32'h0);
    chk("fl_issue", 32'(issue_a), 32'h0);
    nxt();
    set_id(1'b0, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    neg();
    chk("fl_slot_valid", 32'(sv_a), 32'h4);
    chk("fl_count", cnt_a, 32'h1);
    chk("idle_fwd_a", 32'(fa_a), 32'h0);
    chk("idle_issue", 32'(issue_a), 32'h0);
    nxt();

    // Accumulate stalls to 9, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1);
      nxt();
      set_id(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0);
      nxt();
      nxt();
    end
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b1, 1'b0);
    nxt();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd23, 1'b1, 1'b0);
    nxt();
    set_id(1'b1, 5'd23, 1'b1, 5'd22, 1'b1, 5'd24, 1'b1, 1'b0);
    neg();
    chk("pre_rst_slot_valid", 32'(sv_a), 32'h7);
    chk("pre_rst_count", cnt_a, 32'h9);
    chk("pre_rst_fwd_a", 32'(fa_a), 32'h1);
    chk("pre_rst_fwd_b", 32'(fb_a), 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_slot_valid", 32'(sv_a), 32'h0);
    chk("mid_rst_count", cnt_a, 32'h0);
    chk("mid_rst_fwd_a", 32'(fa_a), 32'h0);
    chk("mid_rst_fwd_b", 32'(fb_a), 32'h0);
    chk("mid_rst_stall", 32'(stall_a), 32'h0);

    // Deep instance: two-cycle load-use stall, counter saturation
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);      // LDUR X5
    nxt();
    reset = 1'b1;
    neg();
    chk("d_ld_issue", 32'(issue_b), 32'h1);
    nxt();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    neg();
    chk("d_lu1_stall", 32'(stall_b), 32'h1);
    chk("d_lu1_issue", 32'(issue_b), 32'h0);
    nxt();
    neg();
    chk("d_lu2_stall", 32'(stall_b), 32'h1);
    nxt();
    neg();
    chk("d_lu3_stall", 32'(stall_b), 32'h0);
    chk("d_lu3_fwd_a", 32'(fa_b), 32'h3);
    chk("d_lu3_fwd_b", 32'(fb_b), 32'h3);
    chk("d_lu3_count", 32'(cnt_b), 32'h2);
    chk("d_lu3_slot_valid", 32'(sv_b), 32'h04);
    nxt();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);      // LDUR X8
    nxt();
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    neg();
    chk("d_lu4_stall", 32'(stall_b), 32'h1);
    nxt();
    neg();
    chk("d_lu5_count", 32'(cnt_b), 32'h3);
    nxt();
    neg();
    chk("d_sat_count", 32'(cnt_b), 32'h3);
    chk("d_sat_fwd_a", 32'(fa_b), 32'h3);
    chk("d_sat_issue", 32'(issue_b), 32'h1);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order ARM pipeline.
- Supersedes the fixed two-source forwarding unit. Adds the following:
  - configurable pipeline depth;
  - load-latency-aware load-use stalls;
  - branch flush of younger in-flight slots;
  - zero-register exemption;
  - a saturating stall-cycle counter.
- Sits beside the ID stage. It tracks every issued instruction's destination through the EX..WB slots and drives the operand-forward selects and the stall/bubble controls.

Parameters:
- REG_W, 5: register address width.
- DEPTH, 3: number of in-flight slots after ID (slot 1 = EX, slot DEPTH = WB). Minimum 2.
- LOAD_LAT, 1: a load result becomes forwardable only in slot k > LOAD_LAT. Range 0..DEPTH-1.
- ZERO_REG, 31: register that never creates a hazard (XZR).
- FLUSH_SLOTS, 1: number of youngest slots invalidated by a flush. Range 0..DEPTH.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- id_valid  in  1  ID holds a real instruction.
- id_ra  in  REG_W  first source register.
- id_ra_used  in  1  first source is read.
- id_rb  in  REG_W  second source register (already Reg2Loc-muxed).
- id_rb_used  in  1  second source is read.
- id_rw  in  REG_W  destination register.
- id_wr_en  in  1  instruction writes id_rw.
- id_is_load  in  1  instruction is LDUR-class.
- flush  in  1  branch taken; kill ID and the youngest FLUSH_SLOTS slots.
- fwd_sel_a  out  $clog2(DEPTH+1)  0 = register file; k = forward from slot k.
- fwd_sel_b  out  $clog2(DEPTH+1)  same encoding for the second source.
- stall  out  1  hold PC and IF/ID this cycle.
- issue  out  1  id_valid & ~stall & ~flush; the ID instruction enters slot 1.
- slot_valid  out  DEPTH  per-slot occupancy (debug/verification).
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: DEPTH entries, each {valid, rw, is_load}. Slot 1 is youngest.
- Every clock, entries shift k -> k+1. Slot DEPTH retires (its register-file write occurs on that edge). Slot 1 loads the ID instruction if issue, else a bubble (valid=0).
- Entry matches a source when all of the following hold:
  - valid = 1;
  - entry rw == source register;
  - source_used = 1;
  - source register != ZERO_REG.
  - id_wr_en is captured into the entry. Entries with wr_en = 0 are stored invalid.
- Forward select: choose the lowest k (youngest) matching slot.
  - Available if ~is_load or k > LOAD_LAT → fwd_sel = k.
  - No match → fwd_sel = 0.
- Stall: 1 when id_valid and, for either source, the youngest match is unavailable.
  - The stall repeats each cycle until the producer advances to slot LOAD_LAT+1.
  - Example: with LOAD_LAT=1, load in slot 1 with consumer in ID → exactly one stall cycle.
- During a stall, fwd_sel is don't-care. The bench checks fwd_sel only on issue cycles.
- Flush:
  - Slots 1..FLUSH_SLOTS become invalid in the same edge's shift, i.e. they are not propagated.
  - issue is forced to 0.
  - stall is forced to 0 (flush wins over stall).
  - stall_count does not increment.
- Combinational outputs: stall and fwd_sel are combinational from the ID inputs and slot state, with no added latency. slot_valid and stall_count are registered.
- stall_count increments by 1 on every clock with stall = 1, and saturates at 2^CNT_W-1.
- Reset (asynchronous, mid-operation included): all slots invalid, stall_count = 0. Hence stall = 0, issue = id_valid & ~flush, fwd_sel_a = fwd_sel_b = 0, slot_valid = 0.
- ID register equals its own destination (e.g. ADD X1,X1,X2): the hazard check uses only older slots, never the ID instruction itself.
- id_valid = 0: stall = 0, issue = 0, fwd_sel = 0.

Test Plan:
- Back-to-back ALU: ADD X1 issues, then SUB X3,X1,X2 in ID next cycle → fwd_sel_a = 1, stall = 0. One cycle later, a consumer of X1 gets fwd_sel = 2.
- Load-use (LOAD_LAT=1): LDUR X5 issues, then ADD X6,X5,X5 → stall = 1 for exactly 1 cycle. Then fwd_sel_a = fwd_sel_b = 2, stall_count = 1.
- Youngest wins: ADD X2 then SUB X2 both in flight (slots 2 and 1); consumer of X2 → fwd_sel_a = 1.
- XZR: producer with rw=31, consumer reads X31 → fwd_sel = 0, no stall. Same result when id_ra_used = 0 for a real match.
- Flush: LDUR X7 in slot 1, consumer of X7 in ID, flush = 1 → stall = 0, issue = 0. Next cycle slot_valid[1] = 0 and slot_valid[2] = 0 (FLUSH_SLOTS=1, so the load is dropped and not propagated).
- Reset mid-stream: assert reset low while 3 slots are valid and stall_count = 9 → immediately slot_valid = 0, stall_count = 0, all fwd_sel = 0. Re-run with DEPTH=5, LOAD_LAT=2: load-use → 2 stall cycles, then fwd_sel = 3.
